// File: rtl/acia_sched.sv
// acia_sched: owns the register port of a 6850-style ACIA.
//   - Runs the init sequence (master reset, then CTRL_WORD) after rst.
//   - Polls the status register every max(1, POLL_GAP) idle cycles.
//   - Drains the receiver into a one-entry buffer (rx_*), with priority over
//     TX only while that buffer is empty.
//   - Shares the transmitter round-robin between two byte requesters.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   reqN_valid/data     requester N byte offer (held until reqN_ready)
//   reqN_ready          one-cycle accept strobe, asserted in EVAL
//   rx_valid/data/err   receive buffer; rx_err is status bit 4 for the byte
//   rx_ready            consumer accept (rx_valid & rx_ready pops the byte)
//   acia_cs/we/rs/din   ACIA bus, Moore-decoded from the state register
//   acia_dout           ACIA read data, valid the cycle after a read
//   grant               index of the last accepted requester
module acia_sched #(
  parameter logic [7:0] CTRL_WORD = 8'h15,
  parameter int         POLL_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  input  logic       rx_ready,
  output logic       acia_cs,
  output logic       acia_we,
  output logic       acia_rs,
  output logic [7:0] acia_din,
  input  logic [7:0] acia_dout,
  output logic       grant
);

  localparam logic [2:0] S_INIT_RST = 3'd0;
  localparam logic [2:0] S_INIT_CFG = 3'd1;
  localparam logic [2:0] S_GAP      = 3'd2;
  localparam logic [2:0] S_POLL     = 3'd3;
  localparam logic [2:0] S_EVAL     = 3'd4;
  localparam logic [2:0] S_RXRD     = 3'd5;
  localparam logic [2:0] S_RXCAP    = 3'd6;
  localparam logic [2:0] S_TXWR     = 3'd7;

  // GAP lasts max(1, POLL_GAP) cycles: the counter is loaded with one less
  // than the gap and GAP exits when it reads zero.
  localparam logic [7:0] GAP_LOAD = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

  localparam int ST_RXF = 0;
  localparam int ST_TXE = 1;
  localparam int ST_ERR = 4;

  logic [2:0] state, state_nxt;
  logic [7:0] gap_cnt;
  logic [7:0] tx_hold;
  logic       rx_err_pend;

  // Requester views as packed vectors so arbitration reads uniformly.
  logic [1:0]      req_valid;
  logic [1:0][7:0] req_data;
  assign req_valid = {req1_valid, req0_valid};
  assign req_data  = {req1_data, req0_data};

  // EVAL decisions, made on the status byte returned for the preceding POLL.
  logic rx_go, tx_go, pick1, accept;
  assign rx_go  = acia_dout[ST_RXF] & ~rx_valid;
  assign tx_go  = ~rx_go & acia_dout[ST_TXE] & (|req_valid);
  // On a tie the requester that did not win last time goes next.
  assign pick1  = req_valid[1] & (~req_valid[0] | ~grant);
  // rst gates the strobe so a byte offered in a reset cycle stays with its
  // requester instead of being accepted and then lost.
  assign accept = (state == S_EVAL) & tx_go & ~rst;

  assign req0_ready = accept & ~pick1;
  assign req1_ready = accept &  pick1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT_RST: state_nxt = S_INIT_CFG;
      S_INIT_CFG: state_nxt = S_GAP;
      S_GAP:      if (gap_cnt == 8'd0) state_nxt = S_POLL;
      S_POLL:     state_nxt = S_EVAL;
      S_EVAL: begin
        if (rx_go)      state_nxt = S_RXRD;
        else if (tx_go) state_nxt = S_TXWR;
        else            state_nxt = S_GAP;
      end
      S_RXRD:     state_nxt = S_RXCAP;
      S_RXCAP:    state_nxt = S_GAP;
      S_TXWR:     state_nxt = S_GAP;
      default:    state_nxt = S_INIT_RST;
    endcase
  end

  // Bus decode. The state register sits at INIT_RST throughout rst, so the
  // decode is forced quiet until rst drops; the master-reset write then lands
  // in the first cycle after release.
  always_comb begin
    acia_cs  = 1'b0;
    acia_we  = 1'b0;
    acia_rs  = 1'b0;
    acia_din = 8'h00;
    if (!rst) begin
      case (state)
        S_INIT_RST: begin acia_cs = 1'b1; acia_we = 1'b1; acia_din = 8'h03; end
        S_INIT_CFG: begin acia_cs = 1'b1; acia_we = 1'b1; acia_din = CTRL_WORD; end
        S_POLL:     begin acia_cs = 1'b1; end
        S_RXRD:     begin acia_cs = 1'b1; acia_rs = 1'b1; end
        S_TXWR:     begin acia_cs = 1'b1; acia_we = 1'b1; acia_rs = 1'b1; acia_din = tx_hold; end
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT_RST;
      gap_cnt     <= 8'd0;
      tx_hold     <= 8'h00;
      grant       <= 1'b1;
      rx_err_pend <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      rx_err      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt == S_GAP && state != S_GAP)
        gap_cnt <= GAP_LOAD;
      else if (state == S_GAP && gap_cnt != 8'd0)
        gap_cnt <= gap_cnt - 8'd1;

      if (state == S_EVAL && rx_go)
        rx_err_pend <= acia_dout[ST_ERR];

      if (accept) begin
        tx_hold <= req_data[pick1];
        grant   <= pick1;
      end

      // RXCAP is only reached when the buffer was empty at EVAL, so the
      // set and the consumer clear never meet in the same cycle.
      if (state == S_RXCAP) begin
        rx_data  <= acia_dout;
        rx_err   <= rx_err_pend;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
